// File: rtl/tanh_pkg.sv
// tanh_pkg: shared constants and FSM encoding for the tanh table loader
package tanh_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam int N_DEF = 32;
  localparam int Q_DEF = 16;
  localparam logic [N_DEF-1:0] ONE = N_DEF'(1) << Q_DEF;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;
endpackage

// File: rtl/tanh_entry_checker.sv
// tanh_entry_checker: flags a table word that is negative, above ONE, or below the previous word
//   i_data : incoming table word
//   i_prev : previously accepted word
//   o_ok   : 1 when i_data is a legal next entry
module tanh_entry_checker
  import tanh_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_prev,
  output logic          o_ok
);
  assign o_ok = !i_data[DW-1] && (i_data <= DW'(ONE)) && (i_data >= i_prev);
endmodule

// File: rtl/tanh_lut_writer.sv
// tanh_lut_writer: loads the 2^AW-entry tanh table from a valid/ready stream into a RAM write port
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_start                : begins a load outside LOAD
//   i_s_valid/o_s_ready    : stream handshake, i_s_data word, i_s_last final-word marker
//   o_wr_en/addr/data      : registered table write port (one cycle after the handshake)
//   o_busy/o_done/o_err    : LOAD / sticky success / sticky abort
//   o_checksum             : modulo-2^DW sum of accepted words
//   Macro TANH_LUT_WRITER_CHECK_EN enables value checking (range and monotonicity).
module tanh_lut_writer
  import tanh_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [DW-1:0] i_s_data,
  input  logic          i_s_last,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_checksum
);
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_checksum;
  logic w_hs, w_start, w_cnt_max, w_ok;
  assign w_hs = i_s_valid && (r_state == S_LOAD);
  assign w_start = i_start && (r_state != S_LOAD);
  assign w_cnt_max = &r_cnt;
`ifdef TANH_LUT_WRITER_CHECK_EN
  logic [DW-1:0] r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_prev <= '0;
    else if (w_start) r_prev <= '0;
    else if (w_hs) r_prev <= i_s_data;
  tanh_entry_checker #(.DW(DW)) u_chk (
    .i_data(i_s_data),
    .i_prev(r_prev),
    .o_ok  (w_ok)
  );
`else
  assign w_ok = 1'b1;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // a beat is a length error when s_last disagrees with being the final address
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_LOAD;
    else if (w_hs) w_next = (!w_ok || (i_s_last != w_cnt_max)) ? S_ERR : i_s_last ? S_DONE : S_LOAD;
    o_s_ready = r_state == S_LOAD;
    o_busy = r_state == S_LOAD;
    o_done = r_state == S_DONE;
    o_err = r_state == S_ERR;
  end
  // counter saturates at the last address; the state leaves LOAD on that beat anyway
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_checksum <= '0;
      r_cnt <= '0;
    end else begin
      r_wr_en <= w_hs;
      if (w_hs) begin
        r_wr_addr <= r_cnt;
        r_wr_data <= i_s_data;
        r_checksum <= r_checksum + i_s_data;
        if (!w_cnt_max) r_cnt <= r_cnt + 1'b1;
      end else if (w_start) begin
        r_cnt <= '0;
        r_checksum <= '0;
      end
    end
  assign o_wr_en = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_checksum = r_checksum;
endmodule

// File: tb/tb_tanh_lut_writer.sv
// tb_tanh_lut_writer: directed and randomized loads checked against a table-level outcome model
module tb_tanh_lut_writer;
`ifdef TANH_LUT_WRITER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] ONE = 32'h0001_0000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready, wr_en, busy, done, err;
  logic [9:0] wr_addr;
  logic [31:0] wr_data, checksum;
  int errors = 0, checks = 0;
  logic [31:0] tab[1024];
  logic [9:0] rec_a[$];
  logic [31:0] rec_d[$];
  tanh_lut_writer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_data(s_data), .i_s_last(s_last), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_err(err), .o_checksum(checksum)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (wr_en === 1'b1) begin
      rec_a.push_back(wr_addr);
      rec_d.push_back(wr_data);
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // number of beats the loader accepts before leaving LOAD, and whether it ends in DONE
  function automatic int model(input int last_at, output bit fin_ok);
    logic [31:0] prev = '0;
    fin_ok = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (CHK && (tab[i][31] || tab[i] > ONE || tab[i] < prev)) return i + 1;
      if (i == last_at) begin
        fin_ok = (i == 1023);
        return i + 1;
      end
      prev = tab[i];
    end
    return 1024;
  endfunction
  function automatic void base_table();
    for (int i = 0; i < 1024; i++) tab[i] = (i * 64 > ONE) ? ONE : 32'(i * 64);
  endfunction
  task automatic drive(input int n, input bit gaps, input int last_at, output bit to);
    int i = 0, cyc = 0;
    bit hs;
    while (i < n && cyc < 20000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = s_valid ? tab[i] : $urandom;
      s_last = s_valid && (i == last_at);
      start = gaps && (i == 300);
      hs = s_valid && s_ready;
      @(posedge clk);
      if (hs) i++;
      cyc++;
      if (i < n) @(negedge clk);
    end
    start = 1'b0;
    to = (i < n);
  endtask
  task automatic do_load(input string tag, input int last_at, input bit gaps);
    bit fin, to;
    int n, bad;
    logic [31:0] sum = '0;
    n = model(last_at, fin);
    for (int i = 0; i < n; i++) sum += tab[i];
    @(negedge clk);
    rec_a.delete();
    rec_d.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_in_load"}, 32'(busy), 32'd1);
    drive(n, gaps, last_at, to);
    @(negedge clk);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_ready_after"}, 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data = tab[0];
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_writes"}, 32'(rec_a.size()), 32'(n));
    bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= rec_a.size() || rec_a[i] !== 10'(i) || rec_d[i] !== tab[i]) bad++;
    chk({tag, "_seq_bad"}, 32'(bad), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(fin));
    chk({tag, "_err"}, 32'(err), 32'(!fin));
    chk({tag, "_checksum"}, checksum, sum);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask
  initial begin
    bit to;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    base_table();
    do_load("full", 1023, 1'b0);
    do_load("gaps", 1023, 1'b1);
    do_load("early", 9, 1'b0);
    do_load("nolast", -1, 1'b0);
    tab[4] = 32'h0000_9000;
    tab[5] = 32'h0000_8000;
    do_load("mono", 1023, 1'b0);
    base_table();
    tab[3] = 32'h0001_0001;
    do_load("range", 1023, 1'b0);
    base_table();
    tab[7] = 32'h8000_0000;
    do_load("neg", 1023, 1'b0);
    tab[0] = '0;
    for (int i = 1; i < 1024; i++) begin
      tab[i] = tab[i-1] + $urandom_range(0, 128);
      if (tab[i] > ONE) tab[i] = ONE;
    end
    do_load("rand", 1023, 1'b1);
    base_table();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(500, 1'b0, -1, to);
    chk("midrst_timeout", 32'(to), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load("after_rst", 1023, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
